// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: saturating ADD/SUB, lane-saturating PADDSB, shifts, byte reduce,
// sticky Z/N/V flags written as an op enters stage 2; valid/ready on both sides, flush drops both stages.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             op_err,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4, OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW  = 4'h8, OP_SW  = 4'h9;
  localparam int NBYTES = WIDTH / 8;
  localparam int NLANES = WIDTH / LANE;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [LANE-1:0]  LMAX = {1'b0, {(LANE-1){1'b1}}};
  localparam logic [LANE-1:0]  LMIN = {1'b1, {(LANE-1){1'b0}}};

  logic             s1_valid_q;
  logic [3:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [SHW-1:0]   s1_imm_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             op_err_q;
  logic             flag_z_q;
  logic             flag_n_q;
  logic             flag_v_q;

  logic             s2_adv;
  logic [WIDTH-1:0] res_d;
  logic             err_d;
  logic             upd_z;
  logic             upd_nv;
  logic             z_d;
  logic             n_d;
  logic             v_d;
  logic             ovf;
  logic [WIDTH:0]   ext;
  logic [LANE:0]    lsum;
  logic [WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] rot;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !flush && (!s1_valid_q || s2_adv);
  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign op_err    = op_err_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_v    = flag_v_q;

  always_comb begin
    res_d  = '0;
    err_d  = 1'b0;
    upd_z  = 1'b0;
    upd_nv = 1'b0;
    ovf    = 1'b0;
    ext    = '0;
    lsum   = '0;
    acc    = '0;
    rot    = '0;
    case (s1_op_q)
      OP_ADD, OP_SUB: begin
        // One extra bit holds the exact sum; overflow iff the top two bits disagree.
        if (s1_op_q == OP_ADD) ext = {s1_a_q[WIDTH-1], s1_a_q} + {s1_b_q[WIDTH-1], s1_b_q};
        else                   ext = {s1_a_q[WIDTH-1], s1_a_q} - {s1_b_q[WIDTH-1], s1_b_q};
        ovf    = ext[WIDTH] ^ ext[WIDTH-1];
        res_d  = ovf ? (ext[WIDTH] ? SMIN : SMAX) : ext[WIDTH-1:0];
        upd_z  = 1'b1;
        upd_nv = 1'b1;
      end
      OP_XOR: begin
        res_d = s1_a_q ^ s1_b_q;
        upd_z = 1'b1;
      end
      OP_RED: begin
        for (int i = 0; i < NBYTES; i++) begin
          acc = acc + WIDTH'($signed(s1_a_q[8*i +: 8])) + WIDTH'($signed(s1_b_q[8*i +: 8]));
        end
        res_d = acc;
      end
      OP_SLL: begin
        res_d = s1_a_q << s1_imm_q;
        upd_z = 1'b1;
      end
      OP_SRA: begin
        res_d = $signed(s1_a_q) >>> s1_imm_q;
        upd_z = 1'b1;
      end
      OP_ROR: begin
        rot   = {s1_a_q, s1_a_q} >> s1_imm_q;
        res_d = rot[WIDTH-1:0];
        upd_z = 1'b1;
      end
      OP_PADDSB: begin
        for (int l = 0; l < NLANES; l++) begin
          lsum = {s1_a_q[l*LANE+LANE-1], s1_a_q[l*LANE +: LANE]}
               + {s1_b_q[l*LANE+LANE-1], s1_b_q[l*LANE +: LANE]};
          res_d[l*LANE +: LANE] = (lsum[LANE] ^ lsum[LANE-1]) ? (lsum[LANE] ? LMIN : LMAX)
                                                              : lsum[LANE-1:0];
        end
      end
      OP_LW, OP_SW: res_d = {s1_a_q[WIDTH-1:1], 1'b0} + s1_b_q;
      default:      err_d = 1'b1;
    endcase
    z_d = (res_d == '0);
    n_d = res_d[WIDTH-1];
    v_d = ovf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      op_err_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_v_q   <= 1'b0;
    end else begin
      if (flush)         s1_valid_q <= 1'b0;
      else if (in_ready) s1_valid_q <= in_valid;
      // A flushed op never reaches stage 2, so it cannot touch the flags.
      if (flush) begin
        s2_valid_q <= 1'b0;
      end else if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          result_q <= res_d;
          op_err_q <= err_d;
          if (upd_z) flag_z_q <= z_d;
          if (upd_nv) begin
            flag_n_q <= n_d;
            flag_v_q <= v_d;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_op_q  <= opcode;
      s1_a_q   <= a;
      s1_b_q   <= b;
      s1_imm_q <= imm;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Randomised and directed checks of alu_pipe against an integer-arithmetic reference model,
// for a 16-bit/4-bit-lane instance and a 32-bit/8-bit-lane instance.
module tb_alu_pipe;

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_XOR = 4'h2, OP_RED = 4'h3;
  localparam logic [3:0] OP_SRA = 4'h5, OP_ROR = 4'h6, OP_PADDSB = 4'h7, OP_LW = 4'h8;
  localparam logic [3:0] OP_SLL = 4'h4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, op_err;
  logic [3:0]  opcode, imm;
  logic [15:0] a, b, result;
  logic        flag_z, flag_n, flag_v;

  logic        r2, f2, iv2, ir2, ov2, or2, err2, z2, n2, v2;
  logic [3:0]  op2;
  logic [4:0]  im2;
  logic [31:0] a2, b2, res2;

  alu_pipe #(.WIDTH(16), .LANE(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .op_err(op_err), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  alu_pipe #(.WIDTH(32), .LANE(8)) dut32 (
    .clk(clk), .rst(r2), .flush(f2), .in_valid(iv2), .in_ready(ir2),
    .opcode(op2), .a(a2), .b(b2), .imm(im2), .out_valid(ov2), .out_ready(or2),
    .result(res2), .op_err(err2), .flag_z(z2), .flag_n(n2), .flag_v(v2)
  );

  typedef struct packed { logic [31:0] res; logic err; logic [2:0] f; } exp_t;
  typedef struct packed { logic [15:0] res; logic err; logic [2:0] pre; logic [2:0] post; } ent_t;

  int   checks = 0;
  int   failures = 0;
  ent_t q[$];
  logic [2:0] spec = 3'b000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic longint sx(input longint x, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    x = x & m;
    if (((x >> (w - 1)) & 1) != 0) x = x - (longint'(1) << w);
    return x;
  endfunction

  // Flags are packed {z, n, v}.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                                 input int sh, input int w, input int lane, input logic [2:0] fin);
    exp_t   e;
    longint ua, ub, s, m, hi, lo, r, lm, lh, ll, la, lb;
    m  = (longint'(1) << w) - 1;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -(longint'(1) << (w - 1));
    ua = longint'(ia);
    ub = longint'(ib);
    r  = 0;
    e.err = 1'b0;
    e.f   = fin;
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? sx(ua, w) + sx(ub, w) : sx(ua, w) - sx(ub, w);
        e.f[0] = (s > hi) || (s < lo);
        if (s > hi) s = hi;
        if (s < lo) s = lo;
        r = s & m;
        e.f[2] = (r == 0);
        e.f[1] = (s < 0);
      end
      4'd2: begin r = (ua ^ ub) & m; e.f[2] = (r == 0); end
      4'd3: begin
        s = 0;
        for (int i = 0; i < w / 8; i++) s = s + sx(ua >> (8 * i), 8) + sx(ub >> (8 * i), 8);
        r = s & m;
      end
      4'd4: begin r = (ua << sh) & m; e.f[2] = (r == 0); end
      4'd5: begin r = (sx(ua, w) >>> sh) & m; e.f[2] = (r == 0); end
      4'd6: begin r = ((ua >> sh) | (ua << (w - sh))) & m; e.f[2] = (r == 0); end
      4'd7: begin
        lm = (longint'(1) << lane) - 1;
        lh = (longint'(1) << (lane - 1)) - 1;
        ll = -(longint'(1) << (lane - 1));
        for (int i = 0; i < w / lane; i++) begin
          la = sx(ua >> (i * lane), lane);
          lb = sx(ub >> (i * lane), lane);
          s  = la + lb;
          if (s > lh) s = lh;
          if (s < ll) s = ll;
          r = r | ((s & lm) << (i * lane));
        end
      end
      4'd8, 4'd9: r = ((ua & ~longint'(1)) + ub) & m;
      default: e.err = 1'b1;
    endcase
    e.res = 32'(r);
    return e;
  endfunction

  // One cycle on the 16-bit instance: drive, settle, score the handshakes about to fire.
  task automatic cyc(input logic iv, input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                     input logic [3:0] im, input logic ordy, input logic fl);
    exp_t e;
    ent_t n;
    @(negedge clk);
    in_valid = iv; opcode = op; a = ia; b = ib; imm = im; out_ready = ordy; flush = fl;
    #1;
    if (fl) begin
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && q.size() > 0) spec = q[0].post;
      else if (q.size() > 0)         spec = q[0].pre;
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        else begin
          chk("result", 32'(result), 32'(q[0].res));
          chk("op_err", 32'(op_err), 32'(q[0].err));
          chk("flags", 32'({flag_z, flag_n, flag_v}), 32'(q[0].post));
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() == 0) begin
        chk("flags_idle", 32'({flag_z, flag_n, flag_v}), 32'(spec));
      end
      if (in_valid && in_ready) begin
        e = model(opcode, 32'(a), 32'(b), int'(imm), 16, 4, spec);
        n.res = e.res[15:0]; n.err = e.err; n.pre = spec; n.post = e.f;
        q.push_back(n);
        spec = e.f;
      end
    end
  endtask

  // Accept, then require out_valid exactly two cycles later with the given literal outcome.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] ia, input logic [15:0] ib,
                        input logic [3:0] im, input logic [15:0] er, input logic ee, input logic [2:0] ef);
    cyc(1'b1, op, ia, ib, im, 1'b1, 1'b0);
    chk({tag, "_accept"}, 32'(in_ready), 32'd1);
    cyc(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
    chk({tag, "_lat"}, 32'(out_valid), 32'd0);
    cyc(1'b0, 4'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_err"}, 32'(op_err), 32'(ee));
    chk({tag, "_flags"}, 32'({flag_z, flag_n, flag_v}), 32'(ef));
  endtask

  task automatic cyc32(input logic iv, input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input logic ordy, input logic rv);
    @(negedge clk);
    iv2 = iv; op2 = op; a2 = ia; b2 = ib; im2 = 5'd0; or2 = ordy; r2 = rv;
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 4'h0; a = 16'h0; b = 16'h0; imm = 4'h0;
    r2 = 1'b1; f2 = 1'b0; iv2 = 1'b0; or2 = 1'b0; op2 = 4'h0; a2 = 32'h0; b2 = 32'h0; im2 = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0; r2 = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_op_err", 32'(op_err), 32'd0);
    chk("rst_flags", 32'({flag_z, flag_n, flag_v}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    run_op("add_sat", OP_ADD, 16'h7FFF, 16'h0001, 4'd0, 16'h7FFF, 1'b0, 3'b001);
    run_op("sub_sat", OP_SUB, 16'h8000, 16'h0001, 4'd0, 16'h8000, 1'b0, 3'b011);
    run_op("paddsb", OP_PADDSB, 16'h7711, 16'h1181, 4'd0, 16'h7792, 1'b0, 3'b011);
    run_op("xor_z", OP_XOR, 16'hAAAA, 16'hAAAA, 4'd0, 16'h0000, 1'b0, 3'b111);
    run_op("red", OP_RED, 16'h0102, 16'h03FF, 4'd0, 16'h0005, 1'b0, 3'b111);
    run_op("lw", OP_LW, 16'h1235, 16'h0004, 4'd0, 16'h1238, 1'b0, 3'b111);
    run_op("sra", OP_SRA, 16'h8000, 16'h0000, 4'd15, 16'hFFFF, 1'b0, 3'b011);
    run_op("ror", OP_ROR, 16'h0001, 16'h0000, 4'd1, 16'h8000, 1'b0, 3'b011);
    run_op("ror0", OP_ROR, 16'h1234, 16'h0000, 4'd0, 16'h1234, 1'b0, 3'b011);

    // Consumer stalled: two ops fill the pipe, the third is refused until out_ready rises.
    cyc(1'b1, OP_XOR, 16'h1234, 16'h0000, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, OP_ADD, 16'h0001, 16'h0002, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, OP_SLL, 16'h0001, 16'h0000, 4'd3, 1'b0, 1'b0);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_held", q.size(), 32'd2);
    cyc(1'b1, OP_SLL, 16'h0001, 16'h0000, 4'd3, 1'b0, 1'b0);
    chk("stall_result", 32'(result), 32'h1234);
    cyc(1'b1, OP_SLL, 16'h0001, 16'h0000, 4'd3, 1'b1, 1'b0);
    chk("drain0_vld", 32'(out_valid), 32'd1);
    chk("drain0_res", 32'(result), 32'h1234);
    cyc(1'b0, 4'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    chk("drain1_vld", 32'(out_valid), 32'd1);
    chk("drain1_res", 32'(result), 32'h0003);
    cyc(1'b0, 4'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    chk("drain2_vld", 32'(out_valid), 32'd1);
    chk("drain2_res", 32'(result), 32'h0008);

    run_op("bad_op", 4'hC, 16'h1234, 16'h5678, 4'd0, 16'h0000, 1'b1, 3'b000);

    // Flush with SUB in stage 2 and a zero-producing XOR about to enter it.
    cyc(1'b1, OP_SUB, 16'h0001, 16'h0002, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, OP_XOR, 16'hAAAA, 16'hAAAA, 4'd0, 1'b0, 1'b0);
    cyc(1'b1, OP_ADD, 16'h0005, 16'h0005, 4'd0, 1'b1, 1'b1);
    cyc(1'b0, 4'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    chk("flush_no_vld0", 32'(out_valid), 32'd0);
    chk("flush_flags", 32'({flag_z, flag_n, flag_v}), 32'b010);
    cyc(1'b0, 4'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    chk("flush_no_vld1", 32'(out_valid), 32'd0);
    run_op("post_flush", OP_ADD, 16'h0002, 16'h0003, 4'd0, 16'h0005, 1'b0, 3'b000);

    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
          4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 8 && q.size() > 0; i++) cyc(1'b0, 4'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    chk("random_drained", q.size(), 32'd0);

    cyc32(1'b1, OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b0);
    chk("w32_add_accept", 32'(ir2), 32'd1);
    cyc32(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc32(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("w32_add_vld", 32'(ov2), 32'd1);
    chk("w32_add_res", res2, 32'h7FFFFFFF);
    chk("w32_add_flags", 32'({z2, n2, v2}), 32'b001);
    cyc32(1'b1, OP_PADDSB, 32'h7F0180FF, 32'h0101FF01, 1'b1, 1'b0);
    cyc32(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    cyc32(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("w32_paddsb_res", res2, 32'h7F028000);
    chk("w32_paddsb_model", res2, model(OP_PADDSB, 32'h7F0180FF, 32'h0101FF01, 0, 32, 8, 3'b001).res);

    // Reset while stalled with two ops held.
    cyc32(1'b1, OP_SUB, 32'h00000001, 32'h00000002, 1'b0, 1'b0);
    cyc32(1'b1, OP_XOR, 32'h00000005, 32'h00000003, 1'b0, 1'b0);
    cyc32(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("w32_stall_vld", 32'(ov2), 32'd1);
    chk("w32_stall_full", 32'(ir2), 32'd0);
    chk("w32_stall_res", res2, 32'hFFFFFFFF);
    chk("w32_stall_flags", 32'({z2, n2, v2}), 32'b010);
    cyc32(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    cyc32(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("w32_rst_vld", 32'(ov2), 32'd0);
    chk("w32_rst_res", res2, 32'd0);
    chk("w32_rst_err", 32'(err2), 32'd0);
    chk("w32_rst_flags", 32'({z2, n2, v2}), 32'd0);
    chk("w32_rst_in_ready", 32'(ir2), 32'd1);
    cyc32(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("w32_rst_no_pulse", 32'(ov2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
